// File: rtl/nanorv32_lsu_pkg.sv
// Shared widths, access-size encodings and FSM state encodings for the nanorv32 load/store unit.
package nanorv32_lsu_pkg;

    localparam int NANORV32_DATA_MSB     = 31;
    localparam int NANORV32_LSU_SIZE_MSB = 1;

    typedef logic [NANORV32_LSU_SIZE_MSB:0] lsu_size_t;

    localparam lsu_size_t NANORV32_LSU_SIZE_BYTE = 2'b00;
    localparam lsu_size_t NANORV32_LSU_SIZE_HALF = 2'b01;
    localparam lsu_size_t NANORV32_LSU_SIZE_WORD = 2'b10;

    localparam logic [1:0] NANORV32_LSU_ST_IDLE  = 2'd0;
    localparam logic [1:0] NANORV32_LSU_ST_REQ   = 2'd1;
    localparam logic [1:0] NANORV32_LSU_ST_RWAIT = 2'd2;

endpackage

// File: rtl/nanorv32_lsu_if.sv
// Data-memory port between the load/store unit (master) and the memory (slave).
interface nanorv32_lsu_if;
    import nanorv32_lsu_pkg::*;

    logic                         dmem_req;
    logic                         dmem_we;
    logic [3:0]                   dmem_be;
    logic [NANORV32_DATA_MSB:0]   dmem_addr;
    logic [NANORV32_DATA_MSB:0]   dmem_wdata;
    logic                         dmem_ready;
    logic                         dmem_rvalid;
    logic [NANORV32_DATA_MSB:0]   dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata,
        input  dmem_ready, dmem_rvalid, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata,
        output dmem_ready, dmem_rvalid, dmem_rdata
    );

endinterface

// File: rtl/nanorv32_lsu_align.sv
// Byte-lane steering: store byte enables and replication, load shift and extension, alignment check.
module nanorv32_lsu_align
    import nanorv32_lsu_pkg::*;
(
    input  lsu_size_t                  size,
    input  logic                       is_unsigned,
    input  logic [1:0]                 addr,
    input  logic [NANORV32_DATA_MSB:0] wdata,
    input  logic [NANORV32_DATA_MSB:0] rdata,
    output logic [3:0]                 be,
    output logic [NANORV32_DATA_MSB:0] wdata_rep,
    output logic [NANORV32_DATA_MSB:0] rdata_ext,
    output logic                       misaligned
);

    logic [NANORV32_DATA_MSB:0] rdata_sh;

    assign rdata_sh = rdata >> {addr, 3'b000};

    always_comb begin
        be         = 4'b0000;
        wdata_rep  = wdata;
        rdata_ext  = rdata;
        misaligned = 1'b0;
        case (size)
            NANORV32_LSU_SIZE_BYTE: begin
                be        = 4'b0001 << addr;
                wdata_rep = {4{wdata[7:0]}};
                rdata_ext = is_unsigned ? {24'b0, rdata_sh[7:0]}
                                        : {{24{rdata_sh[7]}}, rdata_sh[7:0]};
            end
            NANORV32_LSU_SIZE_HALF: begin
                be         = 4'b0011 << {addr[1], 1'b0};
                wdata_rep  = {2{wdata[15:0]}};
                rdata_ext  = is_unsigned ? {16'b0, rdata_sh[15:0]}
                                         : {{16{rdata_sh[15]}}, rdata_sh[15:0]};
                misaligned = addr[0];
            end
            NANORV32_LSU_SIZE_WORD: begin
                be         = 4'b1111;
                misaligned = (addr != 2'b00);
            end
            default: misaligned = 1'b1;
        endcase
    end

endmodule

// File: rtl/nanorv32_lsu.sv
// Load/store unit: one outstanding data-memory access, registered outputs, aligned load return.
module nanorv32_lsu
    import nanorv32_lsu_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       lsu_req,
    input  logic                       lsu_we,
    input  lsu_size_t                  lsu_size,
    input  logic                       lsu_unsigned,
    input  logic [NANORV32_DATA_MSB:0] alu_res,
    input  logic [NANORV32_DATA_MSB:0] lsu_wdata,
    output logic                       lsu_busy,
    output logic                       lsu_done,
    output logic                       lsu_misaligned,
    output logic [NANORV32_DATA_MSB:0] lsu_rdata,
    nanorv32_lsu_if.master             dmem
);

    logic [1:0]                 state_q, state_d;
    logic                       busy_q, busy_d;
    logic                       done_q, done_d;
    logic                       mis_q, mis_d;
    logic [NANORV32_DATA_MSB:0] rdata_q, rdata_d;
    logic                       req_q, req_d;
    logic                       we_q, we_d;
    logic [3:0]                 be_q, be_d;
    logic [NANORV32_DATA_MSB:0] addr_q, addr_d;
    logic [NANORV32_DATA_MSB:0] wdata_q, wdata_d;
    lsu_size_t                  size_q, size_d;
    logic                       uns_q, uns_d;
    logic [1:0]                 off_q, off_d;

    // In IDLE the aligner sees the incoming request; afterwards it sees the latched attributes for load return.
    logic                       sel_live;
    lsu_size_t                  al_size;
    logic                       al_uns;
    logic [1:0]                 al_off;
    logic [3:0]                 al_be;
    logic [NANORV32_DATA_MSB:0] al_wdata_rep;
    logic [NANORV32_DATA_MSB:0] al_rdata_ext;
    logic                       al_mis;

    assign sel_live = (state_q == NANORV32_LSU_ST_IDLE);
    assign al_size  = sel_live ? lsu_size      : size_q;
    assign al_uns   = sel_live ? lsu_unsigned  : uns_q;
    assign al_off   = sel_live ? alu_res[1:0]  : off_q;

    nanorv32_lsu_align u_align (
        .size        (al_size),
        .is_unsigned (al_uns),
        .addr        (al_off),
        .wdata       (lsu_wdata),
        .rdata       (dmem.dmem_rdata),
        .be          (al_be),
        .wdata_rep   (al_wdata_rep),
        .rdata_ext   (al_rdata_ext),
        .misaligned  (al_mis)
    );

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        mis_d   = 1'b0;
        rdata_d = rdata_q;
        req_d   = req_q;
        we_d    = we_q;
        be_d    = be_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        size_d  = size_q;
        uns_d   = uns_q;
        off_d   = off_q;
        case (state_q)
            NANORV32_LSU_ST_IDLE: begin
                if (lsu_req) begin
                    if (al_mis) begin
                        done_d = 1'b1;
                        mis_d  = 1'b1;
                    end else begin
                        state_d = NANORV32_LSU_ST_REQ;
                        req_d   = 1'b1;
                        we_d    = lsu_we;
                        be_d    = al_be;
                        addr_d  = {alu_res[NANORV32_DATA_MSB:2], 2'b00};
                        wdata_d = al_wdata_rep;
                        size_d  = lsu_size;
                        uns_d   = lsu_unsigned;
                        off_d   = alu_res[1:0];
                    end
                end
            end
            NANORV32_LSU_ST_REQ: begin
                if (dmem.dmem_ready) begin
                    req_d = 1'b0;
                    if (we_q) begin
                        state_d = NANORV32_LSU_ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = NANORV32_LSU_ST_RWAIT;
                    end
                end
            end
            NANORV32_LSU_ST_RWAIT: begin
                if (dmem.dmem_rvalid) begin
                    rdata_d = al_rdata_ext;
                    done_d  = 1'b1;
                    state_d = NANORV32_LSU_ST_IDLE;
                end
            end
            default: begin
                state_d = NANORV32_LSU_ST_IDLE;
                req_d   = 1'b0;
            end
        endcase
        busy_d = (state_d != NANORV32_LSU_ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= NANORV32_LSU_ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            mis_q   <= 1'b0;
            rdata_q <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            be_q    <= 4'b0000;
            addr_q  <= '0;
            wdata_q <= '0;
            size_q  <= NANORV32_LSU_SIZE_BYTE;
            uns_q   <= 1'b0;
            off_q   <= 2'b00;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            mis_q   <= mis_d;
            rdata_q <= rdata_d;
            req_q   <= req_d;
            we_q    <= we_d;
            be_q    <= be_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            off_q   <= off_d;
        end
    end

    assign lsu_busy        = busy_q;
    assign lsu_done        = done_q;
    assign lsu_misaligned  = mis_q;
    assign lsu_rdata       = rdata_q;
    assign dmem.dmem_req   = req_q;
    assign dmem.dmem_we    = we_q;
    assign dmem.dmem_be    = be_q;
    assign dmem.dmem_addr  = addr_q;
    assign dmem.dmem_wdata = wdata_q;

endmodule

// File: tb/tb_nanorv32_lsu.sv
// Directed bench for nanorv32_lsu: stores, loads, misalignment, reset mid-load and back-to-back issue.
module tb_nanorv32_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        lsu_req;
    logic        lsu_we;
    logic [1:0]  lsu_size;
    logic        lsu_unsigned;
    logic [31:0] alu_res;
    logic [31:0] lsu_wdata;
    logic        lsu_busy;
    logic        lsu_done;
    logic        lsu_misaligned;
    logic [31:0] lsu_rdata;

    int n_chk  = 0;
    int n_fail = 0;

    nanorv32_lsu_if dmem_if ();

    nanorv32_lsu dut (
        .clk            (clk),
        .rst            (rst),
        .lsu_req        (lsu_req),
        .lsu_we         (lsu_we),
        .lsu_size       (lsu_size),
        .lsu_unsigned   (lsu_unsigned),
        .alu_res        (alu_res),
        .lsu_wdata      (lsu_wdata),
        .lsu_busy       (lsu_busy),
        .lsu_done       (lsu_done),
        .lsu_misaligned (lsu_misaligned),
        .lsu_rdata      (lsu_rdata),
        .dmem           (dmem_if)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata);
        lsu_req      = 1'b1;
        lsu_we       = we;
        lsu_size     = size;
        lsu_unsigned = uns;
        alu_res      = addr;
        lsu_wdata    = wdata;
    endtask

    // Zero-wait load: request cycle 0, dmem_req cycle 1, rvalid cycle 2, done cycle 3.
    task automatic do_load(input string tag, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [3:0] exp_be,
                           input logic [31:0] rdata, input logic [31:0] exp_rdata);
        issue(1'b0, size, uns, addr, 32'h0);
        tick();
        lsu_req = 1'b0;
        chk({tag, "_req"},  {31'b0, dmem_if.dmem_req}, 32'd1);
        chk({tag, "_we"},   {31'b0, dmem_if.dmem_we}, 32'd0);
        chk({tag, "_be"},   {28'b0, dmem_if.dmem_be}, {28'b0, exp_be});
        chk({tag, "_addr"}, dmem_if.dmem_addr, {addr[31:2], 2'b00});
        dmem_if.dmem_ready = 1'b1;
        tick();
        dmem_if.dmem_ready  = 1'b0;
        dmem_if.dmem_rvalid = 1'b1;
        dmem_if.dmem_rdata  = rdata;
        chk({tag, "_req_drop"}, {31'b0, dmem_if.dmem_req}, 32'd0);
        chk({tag, "_busy"},     {31'b0, lsu_busy}, 32'd1);
        tick();
        dmem_if.dmem_rvalid = 1'b0;
        chk({tag, "_done"},  {31'b0, lsu_done}, 32'd1);
        chk({tag, "_rdata"}, lsu_rdata, exp_rdata);
        tick();
        chk({tag, "_done_clr"}, {31'b0, lsu_done}, 32'd0);
    endtask

    task automatic do_misaligned(input string tag, input logic [1:0] size, input logic [31:0] addr);
        issue(1'b0, size, 1'b0, addr, 32'h0);
        tick();
        lsu_req = 1'b0;
        chk({tag, "_req"},  {31'b0, dmem_if.dmem_req}, 32'd0);
        chk({tag, "_done"}, {31'b0, lsu_done}, 32'd1);
        chk({tag, "_mis"},  {31'b0, lsu_misaligned}, 32'd1);
        chk({tag, "_busy"}, {31'b0, lsu_busy}, 32'd0);
        tick();
        chk({tag, "_done_clr"}, {31'b0, lsu_done}, 32'd0);
        chk({tag, "_mis_clr"},  {31'b0, lsu_misaligned}, 32'd0);
        chk({tag, "_req2"},     {31'b0, dmem_if.dmem_req}, 32'd0);
    endtask

    initial begin
        rst                 = 1'b1;
        lsu_req             = 1'b0;
        lsu_we              = 1'b0;
        lsu_size            = 2'b00;
        lsu_unsigned        = 1'b0;
        alu_res             = 32'h0;
        lsu_wdata           = 32'h0;
        dmem_if.dmem_ready  = 1'b0;
        dmem_if.dmem_rvalid = 1'b0;
        dmem_if.dmem_rdata  = 32'h0;

        tick();
        tick();
        chk("rst_busy",  {31'b0, lsu_busy}, 32'd0);
        chk("rst_done",  {31'b0, lsu_done}, 32'd0);
        chk("rst_mis",   {31'b0, lsu_misaligned}, 32'd0);
        chk("rst_rdata", lsu_rdata, 32'h0);
        chk("rst_req",   {31'b0, dmem_if.dmem_req}, 32'd0);
        chk("rst_we",    {31'b0, dmem_if.dmem_we}, 32'd0);
        chk("rst_be",    {28'b0, dmem_if.dmem_be}, 32'd0);
        chk("rst_addr",  dmem_if.dmem_addr, 32'h0);
        chk("rst_wdata", dmem_if.dmem_wdata, 32'h0);
        rst = 1'b0;
        tick();
        chk("idle_busy", {31'b0, lsu_busy}, 32'd0);

        // SW 0xDEADBEEF @0x100, zero wait states
        issue(1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF);
        dmem_if.dmem_ready = 1'b1;
        tick();
        lsu_req = 1'b0;
        chk("sw_req",   {31'b0, dmem_if.dmem_req}, 32'd1);
        chk("sw_we",    {31'b0, dmem_if.dmem_we}, 32'd1);
        chk("sw_addr",  dmem_if.dmem_addr, 32'h100);
        chk("sw_be",    {28'b0, dmem_if.dmem_be}, 32'hF);
        chk("sw_wdata", dmem_if.dmem_wdata, 32'hDEADBEEF);
        chk("sw_busy",  {31'b0, lsu_busy}, 32'd1);
        tick();
        dmem_if.dmem_ready = 1'b0;
        chk("sw_done",     {31'b0, lsu_done}, 32'd1);
        chk("sw_mis",      {31'b0, lsu_misaligned}, 32'd0);
        chk("sw_req_drop", {31'b0, dmem_if.dmem_req}, 32'd0);
        chk("sw_idle",     {31'b0, lsu_busy}, 32'd0);
        tick();
        chk("sw_done_clr", {31'b0, lsu_done}, 32'd0);

        // SB 0x123456A5 @0x103 with ready low for three cycles
        issue(1'b1, 2'b00, 1'b0, 32'h103, 32'h123456A5);
        tick();
        lsu_req = 1'b0;
        chk("sb_req",   {31'b0, dmem_if.dmem_req}, 32'd1);
        chk("sb_be",    {28'b0, dmem_if.dmem_be}, 32'h8);
        chk("sb_wdata", dmem_if.dmem_wdata, 32'hA5A5A5A5);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("sb_hold_req",   {31'b0, dmem_if.dmem_req}, 32'd1);
            chk("sb_hold_be",    {28'b0, dmem_if.dmem_be}, 32'h8);
            chk("sb_hold_wdata", dmem_if.dmem_wdata, 32'hA5A5A5A5);
            chk("sb_hold_addr",  dmem_if.dmem_addr, 32'h100);
            chk("sb_hold_done",  {31'b0, lsu_done}, 32'd0);
        end
        dmem_if.dmem_ready = 1'b1;
        tick();
        dmem_if.dmem_ready = 1'b0;
        chk("sb_done",     {31'b0, lsu_done}, 32'd1);
        chk("sb_req_drop", {31'b0, dmem_if.dmem_req}, 32'd0);
        tick();

        // Loads with lane shift and extension
        do_load("lh_s",  2'b01, 1'b0, 32'h202, 4'b1100, 32'h80011234, 32'hFFFF8001);
        do_load("lh_u",  2'b01, 1'b1, 32'h202, 4'b1100, 32'h80011234, 32'h00008001);
        do_load("lb_s",  2'b00, 1'b0, 32'h201, 4'b0010, 32'h0000F000, 32'hFFFFFFF0);
        do_load("lw",    2'b10, 1'b0, 32'h204, 4'b1111, 32'h89ABCDEF, 32'h89ABCDEF);
        do_load("lbu_3", 2'b00, 1'b1, 32'h203, 4'b1000, 32'h9A000000, 32'h0000009A);

        // Rejected accesses
        do_misaligned("mis_lw",  2'b10, 32'h102);
        do_misaligned("mis_lh",  2'b01, 32'h201);
        do_misaligned("mis_s11", 2'b11, 32'h0);

        // Reset while in RWAIT, rvalid one cycle later must be discarded
        issue(1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
        tick();
        lsu_req = 1'b0;
        dmem_if.dmem_ready = 1'b1;
        tick();
        dmem_if.dmem_ready = 1'b0;
        chk("rw_busy", {31'b0, lsu_busy}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        dmem_if.dmem_rvalid = 1'b1;
        dmem_if.dmem_rdata  = 32'h11111111;
        chk("rw_rst_done",  {31'b0, lsu_done}, 32'd0);
        chk("rw_rst_busy",  {31'b0, lsu_busy}, 32'd0);
        chk("rw_rst_req",   {31'b0, dmem_if.dmem_req}, 32'd0);
        chk("rw_rst_rdata", lsu_rdata, 32'h0);
        tick();
        dmem_if.dmem_rvalid = 1'b0;
        chk("rw_late_done",  {31'b0, lsu_done}, 32'd0);
        chk("rw_late_rdata", lsu_rdata, 32'h0);
        chk("rw_late_busy",  {31'b0, lsu_busy}, 32'd0);
        tick();

        // Back-to-back: LW with delayed rvalid, busy-time request ignored, SW issued in done cycle
        issue(1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
        tick();
        lsu_req = 1'b0;
        chk("bb_lw_req", {31'b0, dmem_if.dmem_req}, 32'd1);
        dmem_if.dmem_ready = 1'b1;
        tick();
        dmem_if.dmem_ready = 1'b0;
        issue(1'b1, 2'b10, 1'b0, 32'h300, 32'h77777777);
        tick();
        lsu_req = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("bb_wait_req",  {31'b0, dmem_if.dmem_req}, 32'd0);
            chk("bb_wait_we",   {31'b0, dmem_if.dmem_we}, 32'd0);
            chk("bb_wait_busy", {31'b0, lsu_busy}, 32'd1);
            chk("bb_wait_done", {31'b0, lsu_done}, 32'd0);
            tick();
        end
        dmem_if.dmem_rvalid = 1'b1;
        dmem_if.dmem_rdata  = 32'hCAFEF00D;
        tick();
        dmem_if.dmem_rvalid = 1'b0;
        chk("bb_lw_done",  {31'b0, lsu_done}, 32'd1);
        chk("bb_lw_rdata", lsu_rdata, 32'hCAFEF00D);
        chk("bb_lw_req0",  {31'b0, dmem_if.dmem_req}, 32'd0);
        issue(1'b1, 2'b10, 1'b0, 32'h40, 32'h000055AA);
        dmem_if.dmem_ready = 1'b1;
        tick();
        lsu_req = 1'b0;
        chk("bb_sw_req",   {31'b0, dmem_if.dmem_req}, 32'd1);
        chk("bb_sw_we",    {31'b0, dmem_if.dmem_we}, 32'd1);
        chk("bb_sw_addr",  dmem_if.dmem_addr, 32'h40);
        chk("bb_sw_wdata", dmem_if.dmem_wdata, 32'h000055AA);
        tick();
        dmem_if.dmem_ready = 1'b0;
        chk("bb_sw_done",  {31'b0, lsu_done}, 32'd1);
        chk("bb_rdata_kept", lsu_rdata, 32'hCAFEF00D);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/nanorv32_lsu.md
Name: nanorv32_lsu

Overview:
Load/store unit directly downstream of the ALU. It consumes the ALU result as the effective address, plus rs2 store data and access attributes from the decoder. It generates byte-lane-aligned requests on the data-memory port, with at most one access outstanding. For loads it returns the aligned, sign- or zero-extended read data to the writeback mux.

Parameters:
NANORV32_DATA_MSB, 31, data and address MSB; comes from the shared parameters include, not a module parameter.
NANORV32_LSU_SIZE_MSB, 1, MSB of the access-size field; comes from the shared include.

Ports:
clk  in  1  core clock
rst  in  1  reset; synchronous, active-high
lsu_req  in  1  start access; sampled only when lsu_busy=0
lsu_we  in  1  1=store, 0=load
lsu_size  in  2  00 byte, 01 half, 10 word, 11 illegal
lsu_unsigned  in  1  load zero-extends (LBU/LHU)
alu_res  in  32  effective address from ALU
lsu_wdata  in  32  store data (rs2)
lsu_busy  out  1  state != IDLE
lsu_done  out  1  one-cycle pulse: access complete or rejected
lsu_misaligned  out  1  one-cycle pulse, coincident with lsu_done, on rejected access
lsu_rdata  out  32  load result; held until the next load completes
dmem_req  out  1  request valid
dmem_we  out  1  write enable
dmem_be  out  4  byte enables
dmem_addr  out  32  word-aligned address ({alu_res[31:2],2'b00})
dmem_wdata  out  32  lane-replicated store data
dmem_ready  in  1  request accepted when dmem_req&dmem_ready
dmem_rvalid  in  1  read data valid; earliest 1 cycle after acceptance
dmem_rdata  in  32  read data

Behaviour:
- Reset: state=IDLE. All outputs 0: lsu_busy, lsu_done, lsu_misaligned, lsu_rdata, dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata.
- All outputs are registered.
- FSM states: IDLE, REQ, RWAIT.
- IDLE, lsu_req=1, access misaligned: stay in IDLE; next cycle lsu_done=1 and lsu_misaligned=1; no dmem_req.
  - Misaligned means: half with addr[0]=1; word with addr[1:0]!=0; size 11 with any address.
- IDLE, lsu_req=1, access legal: go to REQ. At the same edge, latch dmem_addr, dmem_we, dmem_be, dmem_wdata, size, unsigned and addr[1:0]. dmem_req=1 from the next cycle.
- REQ: dmem_* held stable while dmem_ready=0.
  - On dmem_req&dmem_ready with a store: go to IDLE, dmem_req=0, lsu_done pulse next cycle.
  - On dmem_req&dmem_ready with a load: go to RWAIT, dmem_req=0.
- RWAIT: on dmem_rvalid, lsu_rdata is updated and lsu_done pulses next cycle; go to IDLE.
- Latency with zero wait states:
  - store: req at cycle 0, dmem_req at cycle 1, done at cycle 2.
  - load: rvalid at cycle 2, done and rdata at cycle 3.
- Byte enables:
  - byte: 4'b0001<<addr[1:0]
  - half: 4'b0011<<{addr[1],1'b0}
  - word: 4'b1111
- Store data: byte {4{wdata[7:0]}}; half {2{wdata[15:0]}}; word unchanged.
- Load data: dmem_rdata>>(8*addr[1:0]). Then take bits [7:0] for byte or [15:0] for half. Sign-extend, or zero-extend when lsu_unsigned=1. Word loads pass through unchanged.
- lsu_req while lsu_busy=1 is ignored; the control unit stalls on lsu_busy.
- lsu_req is accepted back-to-back in the cycle where lsu_done=1, because the FSM is already in IDLE.
- dmem_rvalid outside RWAIT is ignored.
- dmem_ready outside REQ is ignored.
- rst asserted in any state: IDLE at the next edge, dmem_req=0, no lsu_done. A late rvalid after reset is discarded.
- No bus-error support; no timeout.

Decomposition:
- Shared include (nanorv32_parameters.v): NANORV32_LSU_SIZE_BYTE/HALF/WORD encodings, NANORV32_LSU_SIZE_MSB, FSM state encodings NANORV32_LSU_ST_IDLE/REQ/RWAIT.
- One combinational sub-module, nanorv32_lsu_align:
  - inputs: size, unsigned, addr[1:0], wdata, rdata.
  - outputs: be, wdata_rep, rdata_ext, misaligned.
- The top level holds the FSM and all registers.

Test Plan:
- Reset: hold rst 2 cycles, then release -> all outputs 0 and lsu_busy=0. Raise rst while in RWAIT, with rvalid arriving 1 cycle later -> no lsu_done, lsu_rdata unchanged.
- SW 0xDEADBEEF @0x100, dmem_ready=1 -> cycle 1: dmem_addr=0x100, be=1111, wdata=0xDEADBEEF. Cycle 2: lsu_done=1.
- SB 0x123456A5 @0x103, dmem_ready low for 3 cycles -> be=1000 and wdata=0xA5A5A5A5, held stable for 4 cycles. lsu_done 1 cycle after acceptance.
- LH @0x202, rdata 0x8001_1234 -> lsu_rdata=0xFFFF8001. Same with lsu_unsigned=1 -> 0x00008001. LB @0x201, rdata 0x0000_F000 -> 0xFFFFFFF0.
- LW @0x102 -> no dmem_req; lsu_done=1 and lsu_misaligned=1 next cycle. LH @0x201 and size=11 @0x0 behave the same.
- Back-to-back: LW @0x0 with rvalid delayed 3 cycles, a second lsu_req issued during busy, then a new SW in the lsu_done cycle -> the busy-time request is ignored and the SW's dmem_req appears the cycle after lsu_done.
